// File: rtl/cache_hier_ctrl.sv
// Two-level read hierarchy controller: L1 -> L2 -> memory lookup with fills,
// memory timeout error responses and saturating hit/miss/error counters.
module cache_hier_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic [1:0]            cpu_resp_src,
  output logic                  l1_lookup,
  input  logic                  l1_ack,
  input  logic                  l1_hit,
  input  logic [DATA_WIDTH-1:0] l1_rdata,
  output logic                  l2_lookup,
  input  logic                  l2_ack,
  input  logic                  l2_hit,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  output logic                  l1_fill,
  output logic                  l2_fill,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [ADDR_WIDTH-1:0] line_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [CNT_WIDTH-1:0]  cnt_l1_hit,
  output logic [CNT_WIDTH-1:0]  cnt_l2_hit,
  output logic [CNT_WIDTH-1:0]  cnt_miss,
  output logic [CNT_WIDTH-1:0]  cnt_err
);

  typedef enum logic [2:0] {
    IDLE,
    L1_LOOK,
    L2_LOOK,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_e;

  localparam logic [1:0]  SRC_L1    = 2'd0;
  localparam logic [1:0]  SRC_L2    = 2'd1;
  localparam logic [1:0]  SRC_MEM   = 2'd2;
  localparam logic [1:0]  SRC_ERR   = 2'd3;
  localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            src_q, src_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [15:0]           tmo_inc;
  logic [CNT_WIDTH-1:0]  cnt_l1_hit_q, cnt_l1_hit_d;
  logic [CNT_WIDTH-1:0]  cnt_l2_hit_q, cnt_l2_hit_d;
  logic [CNT_WIDTH-1:0]  cnt_miss_q, cnt_miss_d;
  logic [CNT_WIDTH-1:0]  cnt_err_q, cnt_err_d;
  logic                  inc_l1, inc_l2, inc_miss, inc_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != '1)) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  assign tmo_inc = tmo_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    data_d      = data_q;
    src_d       = src_q;
    tmo_d       = tmo_q;
    inc_l1      = 1'b0;
    inc_l2      = 1'b0;
    inc_miss    = 1'b0;
    inc_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          line_addr_d = cpu_addr;
          state_d     = L1_LOOK;
        end
      end
      L1_LOOK: begin
        if (l1_ack) begin
          if (l1_hit) begin
            data_d  = l1_rdata;
            src_d   = SRC_L1;
            inc_l1  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = L2_LOOK;
          end
        end
      end
      L2_LOOK: begin
        if (l2_ack) begin
          if (l2_hit) begin
            data_d  = l2_rdata;
            src_d   = SRC_L2;
            inc_l2  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) begin
          tmo_d   = '0;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // A response on the same edge as the timeout takes priority.
        if (mem_resp_valid) begin
          data_d   = mem_resp_data;
          src_d    = SRC_MEM;
          inc_miss = 1'b1;
          state_d  = RESP;
        end else if (tmo_inc == TMO_LIMIT) begin
          data_d  = '0;
          src_d   = SRC_ERR;
          inc_err = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_l1_hit_d = sat_inc(cnt_l1_hit_q, inc_l1);
    cnt_l2_hit_d = sat_inc(cnt_l2_hit_q, inc_l2);
    cnt_miss_d   = sat_inc(cnt_miss_q, inc_miss);
    cnt_err_d    = sat_inc(cnt_err_q, inc_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      data_q       <= '0;
      src_q        <= '0;
      tmo_q        <= '0;
      cnt_l1_hit_q <= '0;
      cnt_l2_hit_q <= '0;
      cnt_miss_q   <= '0;
      cnt_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      data_q       <= data_d;
      src_q        <= src_d;
      tmo_q        <= tmo_d;
      cnt_l1_hit_q <= cnt_l1_hit_d;
      cnt_l2_hit_q <= cnt_l2_hit_d;
      cnt_miss_q   <= cnt_miss_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads zero.
  assign cpu_req_ready  = (state_q == IDLE) && !rst;
  assign l1_lookup      = (state_q == L1_LOOK);
  assign l2_lookup      = (state_q == L2_LOOK);
  assign mem_req_valid  = (state_q == MEM_REQ);
  assign cpu_resp_valid = (state_q == RESP);
  assign l1_fill        = (state_q == RESP) && ((src_q == SRC_L2) || (src_q == SRC_MEM));
  assign l2_fill        = (state_q == RESP) && (src_q == SRC_MEM);
  assign cpu_resp_data  = data_q;
  assign cpu_resp_src   = src_q;
  assign fill_data      = data_q;
  assign line_addr      = line_addr_q;
  assign cnt_l1_hit     = cnt_l1_hit_q;
  assign cnt_l2_hit     = cnt_l2_hit_q;
  assign cnt_miss       = cnt_miss_q;
  assign cnt_err        = cnt_err_q;

endmodule

// File: tb/tb_cache_hier_ctrl.sv
// Randomized bench for cache_hier_ctrl: a reactive cache/memory environment
// plus a transaction-level model predicting source, data, latency and counters.
module tb_cache_hier_ctrl;
  localparam int unsigned AW   = 11;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 2;
  localparam int unsigned TMO  = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid, cpu_req_ready;
  logic [AW-1:0] cpu_addr;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_data;
  logic [1:0]    cpu_resp_src;
  logic          l1_lookup, l1_ack, l1_hit;
  logic [DW-1:0] l1_rdata;
  logic          l2_lookup, l2_ack, l2_hit;
  logic [DW-1:0] l2_rdata;
  logic          l1_fill, l2_fill;
  logic [DW-1:0] fill_data;
  logic [AW-1:0] line_addr;
  logic          mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [CW-1:0] cnt_l1_hit, cnt_l2_hit, cnt_miss, cnt_err;

  cache_hier_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_addr      (cpu_addr),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data (cpu_resp_data),
    .cpu_resp_src  (cpu_resp_src),
    .l1_lookup     (l1_lookup),
    .l1_ack        (l1_ack),
    .l1_hit        (l1_hit),
    .l1_rdata      (l1_rdata),
    .l2_lookup     (l2_lookup),
    .l2_ack        (l2_ack),
    .l2_hit        (l2_hit),
    .l2_rdata      (l2_rdata),
    .l1_fill       (l1_fill),
    .l2_fill       (l2_fill),
    .fill_data     (fill_data),
    .line_addr     (line_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .cnt_l1_hit    (cnt_l1_hit),
    .cnt_l2_hit    (cnt_l2_hit),
    .cnt_miss      (cnt_miss),
    .cnt_err       (cnt_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scenario for the current transaction, consumed by the environment.
  int          d1, d2, dr, dm;
  bit          h1, h2, tmo_mode;
  logic [DW-1:0] r1, r2, rm;
  bit          noise_en   = 1'b0;
  bit          force_resp = 1'b0;

  // Reference model counters.
  int m_l1, m_l2, m_miss, m_err;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  // Reactive L1/L2/memory environment; spurious handshakes when not addressed.
  int c1, c2, cr, cw;
  bit waiting, rdy_prev;
  initial begin : env
    forever begin
      @(negedge clk);
      if (rst) begin
        c1 = 0; c2 = 0; cr = 0; cw = 0; waiting = 1'b0; rdy_prev = 1'b0;
        l1_ack = 1'b0; l1_hit = 1'b0; l1_rdata = '0;
        l2_ack = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      end else begin
        if (rdy_prev) begin
          waiting = 1'b1;
          cw = 0;
        end
        if (waiting && cpu_resp_valid) waiting = 1'b0;

        l1_ack = noise_en && ($urandom_range(0, 3) == 0);
        l1_hit = 1'($urandom_range(0, 1));
        l1_rdata = DW'($urandom);
        if (l1_lookup) begin
          l1_ack = (c1 == d1);
          if (l1_ack) begin l1_hit = h1; l1_rdata = r1; end
          c1++;
        end else c1 = 0;

        l2_ack = noise_en && ($urandom_range(0, 3) == 0);
        l2_hit = 1'($urandom_range(0, 1));
        l2_rdata = DW'($urandom);
        if (l2_lookup) begin
          l2_ack = (c2 == d2);
          if (l2_ack) begin l2_hit = h2; l2_rdata = r2; end
          c2++;
        end else c2 = 0;

        mem_req_ready = noise_en && ($urandom_range(0, 3) == 0);
        if (mem_req_valid) begin
          mem_req_ready = (cr == dr);
          cr++;
        end else cr = 0;
        rdy_prev = mem_req_valid && mem_req_ready;

        mem_resp_data  = DW'($urandom);
        mem_resp_valid = force_resp || (noise_en && !waiting && ($urandom_range(0, 3) == 0));
        if (waiting) begin
          mem_resp_valid = 1'b0;
          if (!tmo_mode && (cw == dm)) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = rm;
            waiting        = 1'b0;
          end else cw++;
        end
      end
    end
  end

  task automatic set_scn(input bit a_h1, input int a_d1, input logic [DW-1:0] a_r1,
                         input bit a_h2, input int a_d2, input logic [DW-1:0] a_r2,
                         input int a_dr, input int a_dm, input bit a_tmo,
                         input logic [DW-1:0] a_rm);
    h1 = a_h1; d1 = a_d1; r1 = a_r1;
    h2 = a_h2; d2 = a_d2; r2 = a_r2;
    dr = a_dr; dm = a_dm; tmo_mode = a_tmo; rm = a_rm;
  endtask

  task automatic chk_counters();
    chk("cnt_l1_hit", 64'(cnt_l1_hit), 64'(m_l1));
    chk("cnt_l2_hit", 64'(cnt_l2_hit), 64'(m_l2));
    chk("cnt_miss", 64'(cnt_miss), 64'(m_miss));
    chk("cnt_err", 64'(cnt_err), 64'(m_err));
  endtask

  task automatic chk_zero_outs();
    chk("rst_ctrl_outs", 64'({cpu_req_ready, cpu_resp_valid, l1_lookup, l2_lookup,
                              mem_req_valid, l1_fill, l2_fill}), 64'd0);
    chk("rst_resp_data", 64'(cpu_resp_data), 64'd0);
    chk("rst_fill_data", 64'(fill_data), 64'd0);
    chk("rst_resp_src", 64'(cpu_resp_src), 64'd0);
    chk("rst_line_addr", 64'(line_addr), 64'd0);
    chk_counters();
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic do_txn(input logic [AW-1:0] addr);
    int            exp_lat, cyc;
    logic [1:0]    esrc;
    logic [DW-1:0] edata;
    if (h1) begin
      esrc = 2'd0; edata = r1; exp_lat = 2 + d1; m_l1 = sat(m_l1);
    end else if (h2) begin
      esrc = 2'd1; edata = r2; exp_lat = 3 + d1 + d2; m_l2 = sat(m_l2);
    end else if (!tmo_mode) begin
      esrc = 2'd2; edata = rm; exp_lat = 5 + d1 + d2 + dr + dm; m_miss = sat(m_miss);
    end else begin
      esrc = 2'd3; edata = '0; exp_lat = 4 + d1 + d2 + dr + TMO; m_err = sat(m_err);
    end

    chk("req_ready", 64'(cpu_req_ready), 64'd1);
    cpu_req_valid = 1'b1;
    cpu_addr      = addr;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cyc = 1;
    while (!cpu_resp_valid && cyc < 100) begin
      chk("fill_idle", 64'({l1_fill, l2_fill}), 64'd0);
      cpu_addr = AW'($urandom);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("resp_src", 64'(cpu_resp_src), 64'(esrc));
    chk("resp_data", 64'(cpu_resp_data), 64'(edata));
    chk("fill_data", 64'(fill_data), 64'(edata));
    chk("l1_fill", 64'(l1_fill), 64'((esrc == 2'd1) || (esrc == 2'd2)));
    chk("l2_fill", 64'(l2_fill), 64'(esrc == 2'd2));
    chk("line_addr", 64'(line_addr), 64'(addr));
    chk_counters();
    @(negedge clk);
    chk("resp_one_cycle", 64'({cpu_resp_valid, l1_fill, l2_fill}), 64'd0);
    chk("resp_data_hold", 64'(cpu_resp_data), 64'(edata));
    chk("resp_src_hold", 64'(cpu_resp_src), 64'(esrc));
    chk("ready_after", 64'(cpu_req_ready), 64'd1);
  endtask

  // Called at a negedge; asserts reset asynchronously mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    m_l1 = 0; m_l2 = 0; m_miss = 0; m_err = 0;
    #1 chk_zero_outs();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int kind;
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_addr = '0;
    set_scn(1'b0, 0, '0, 1'b0, 0, '0, 0, 0, 1'b0, '0);
    m_l1 = 0; m_l2 = 0; m_miss = 0; m_err = 0;
    repeat (2) @(negedge clk);
    chk_zero_outs();
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_post_reset", 64'(cpu_req_ready), 64'd1);

    // L1 hit, minimum latency.
    set_scn(1'b1, 0, 32'hDEADBEEF, 1'b0, 0, '0, 0, 0, 1'b0, '0);
    do_txn(11'h123);
    // L2 hit with slow caches.
    set_scn(1'b0, 3, 32'h11111111, 1'b1, 2, 32'h0000A5A5, 0, 0, 1'b0, '0);
    do_txn(11'h2A4);
    // Full miss with slow memory ready.
    set_scn(1'b0, 0, '0, 1'b0, 0, '0, 4, 0, 1'b0, 32'hCAFEBABE);
    do_txn(11'h7FF);
    // Response on the same edge the timeout would fire.
    set_scn(1'b0, 0, '0, 1'b0, 0, '0, 0, TMO - 1, 1'b0, 32'h0BADF00D);
    do_txn(11'h055);
    // Timeout, then a late memory response that must be ignored.
    set_scn(1'b0, 0, '0, 1'b0, 0, '0, 1, 0, 1'b1, '0);
    do_txn(11'h400);
    force_resp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_resp_ignored", 64'(cpu_resp_valid), 64'd0);
    end
    force_resp = 1'b0;
    chk_counters();

    // Reset while waiting on memory, followed by a late response.
    @(negedge clk);
    set_scn(1'b0, 0, '0, 1'b0, 0, '0, 0, 0, 1'b1, '0);
    cpu_req_valid = 1'b1;
    cpu_addr = 11'h3C3;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    m_l1 = 0; m_l2 = 0; m_miss = 0; m_err = 0;
    #1 chk_zero_outs();
    @(negedge clk);
    #1 rst = 1'b0;
    force_resp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_resp", 64'({cpu_resp_valid, mem_req_valid, l1_lookup}), 64'd0);
      chk("post_rst_ready", 64'(cpu_req_ready), 64'd1);
    end
    force_resp = 1'b0;
    chk_zero_outs_after_release();

    // Five L1 hits saturate a 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      set_scn(1'b1, $urandom_range(0, 2), DW'($urandom), 1'b0, 0, '0, 0, 0, 1'b0, '0);
      do_txn(AW'($urandom));
    end
    chk("cnt_l1_sat", 64'(cnt_l1_hit), 64'd3);

    // Randomized traffic with spurious handshakes and occasional resets.
    noise_en = 1'b1;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 3);
      set_scn(kind == 0, $urandom_range(0, 4), DW'($urandom),
              kind == 1, $urandom_range(0, 4), DW'($urandom),
              $urandom_range(0, 4), $urandom_range(0, TMO - 1), kind == 3,
              DW'($urandom));
      do_txn(AW'($urandom));
      if ((n % 40) == 39) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic chk_zero_outs_after_release();
    chk("post_rst_line_addr", 64'(line_addr), 64'd0);
    chk("post_rst_data", 64'(cpu_resp_data), 64'd0);
    chk("post_rst_src", 64'(cpu_resp_src), 64'd0);
    chk_counters();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
